// File: rtl/dmem_cache_responder_if.sv
// Core-side data port plus the main-memory request/response bus.
// The slave modport is the responder's view; the master modport is the
// core/memory side that drives requests and answers memory transactions.
interface dmem_cache_responder_if #(
  parameter int MEM_TAG_W = 5
);
  // core data port
  logic [31:0]          cpu_addr;
  logic                 cpu_re;
  logic [3:0]           cpu_we;
  logic [31:0]          cpu_din;
  logic [31:0]          cpu_dout;
  logic                 stall;
  // main-memory request channel
  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic                 mem_req_rw;
  logic [27:0]          mem_req_addr;
  logic [MEM_TAG_W-1:0] mem_req_tag;
  // main-memory write-data channel
  logic                 mem_req_data_valid;
  logic                 mem_req_data_ready;
  logic [127:0]         mem_req_data_bits;
  logic [15:0]          mem_req_data_mask;
  // main-memory read response
  logic                 mem_resp_valid;
  logic [127:0]         mem_resp_data;
  logic [MEM_TAG_W-1:0] mem_resp_tag;

  modport slave (
    input  cpu_addr, cpu_re, cpu_we, cpu_din,
    output cpu_dout, stall,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
    input  mem_req_ready,
    output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    input  mem_req_data_ready,
    input  mem_resp_valid, mem_resp_data, mem_resp_tag
  );

  modport master (
    output cpu_addr, cpu_re, cpu_we, cpu_din,
    input  cpu_dout, stall,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
    output mem_req_ready,
    input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    output mem_req_data_ready,
    output mem_resp_valid, mem_resp_data, mem_resp_tag
  );
endinterface

// File: rtl/dmem_cache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache responder.
// Read hits return one cycle later without stalling; read misses refill a
// 128-bit line from main memory; every write goes through to memory and
// updates the cached line only on a hit.
module dmem_cache_responder #(
  parameter int LINES     = 64,
  parameter int MEM_TAG_W = 5,
  parameter int REQ_TAG   = 0
) (
  input  logic clk,
  input  logic reset,
  dmem_cache_responder_if.slave bus
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;
  localparam logic [MEM_TAG_W-1:0] RTAG = MEM_TAG_W'(REQ_TAG);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;
  state_t state, state_n;

  // cache storage; only the valid bits need a reset
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [127:0]     data_arr [LINES];

  // address of the transaction in flight
  logic [31:2] lat_addr;

  // registered outputs
  logic [31:0]          dout_q;
  logic                 stall_q;
  logic                 req_valid_q;
  logic                 req_rw_q;
  logic [27:0]          req_addr_q;
  logic [MEM_TAG_W-1:0] req_tag_q;
  logic                 wd_valid_q;
  logic [127:0]         wd_bits_q;
  logic [15:0]          wd_mask_q;

  // byte-in-word bits carry no information for a word-wide port
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.cpu_addr[1:0];

  // request decode against the live core address
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       off;
  assign idx = bus.cpu_addr[4 +: IDX_W];
  assign tag = bus.cpu_addr[31 -: TAG_W];
  assign off = bus.cpu_addr[3:2];

  // decode of the latched address for refill completion
  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic [1:0]       l_off;
  assign l_idx = lat_addr[4 +: IDX_W];
  assign l_tag = lat_addr[31 -: TAG_W];
  assign l_off = lat_addr[3:2];

  logic        hit, is_wr, rd_hit, rd_miss, resp_ok, req_done, wd_done;
  logic [31:0] hit_word, resp_word;

  assign hit       = valid[idx] && (tag_arr[idx] == tag);
  assign is_wr     = |bus.cpu_we;
  assign rd_hit    = bus.cpu_re && !is_wr && hit;
  assign rd_miss   = bus.cpu_re && !is_wr && !hit;
  assign resp_ok   = bus.mem_resp_valid && (bus.mem_resp_tag == RTAG);
  // a channel counts as done once its valid has dropped or is handshaking now
  assign req_done  = !req_valid_q || bus.mem_req_ready;
  assign wd_done   = !wd_valid_q  || bus.mem_req_data_ready;
  assign hit_word  = data_arr[idx][{off, 5'b0} +: 32];
  assign resp_word = bus.mem_resp_data[{l_off, 5'b0} +: 32];

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (is_wr)                 state_n = WR_REQ;
               else if (rd_miss)          state_n = RD_REQ;
      RD_REQ:  if (bus.mem_req_ready)     state_n = RD_WAIT;
      RD_WAIT: if (resp_ok)               state_n = IDLE;
      WR_REQ:  if (req_done && wd_done)   state_n = IDLE;
      default:                            state_n = IDLE;
    endcase
  end

  // registered outputs, valid bits and the in-flight address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid       <= '0;
      lat_addr    <= '0;
      dout_q      <= '0;
      stall_q     <= 1'b0;
      req_valid_q <= 1'b0;
      req_rw_q    <= 1'b0;
      req_addr_q  <= '0;
      req_tag_q   <= '0;
      wd_valid_q  <= 1'b0;
      wd_bits_q   <= '0;
      wd_mask_q   <= '0;
    end else begin
      stall_q <= (state_n != IDLE);
      case (state)
        IDLE: begin
          if (is_wr) begin
            lat_addr    <= bus.cpu_addr[31:2];
            req_valid_q <= 1'b1;
            req_rw_q    <= 1'b1;
            req_addr_q  <= bus.cpu_addr[31:4];
            req_tag_q   <= RTAG;
            wd_valid_q  <= 1'b1;
            wd_bits_q   <= {4{bus.cpu_din}};
            wd_mask_q   <= 16'(bus.cpu_we) << {off, 2'b0};
          end else if (rd_miss) begin
            lat_addr    <= bus.cpu_addr[31:2];
            req_valid_q <= 1'b1;
            req_rw_q    <= 1'b0;
            req_addr_q  <= bus.cpu_addr[31:4];
            req_tag_q   <= RTAG;
          end else if (rd_hit) begin
            dout_q <= hit_word;
          end
        end
        RD_REQ: if (bus.mem_req_ready) req_valid_q <= 1'b0;
        RD_WAIT: if (resp_ok) begin
          valid[l_idx] <= 1'b1;
          dout_q       <= resp_word;
        end
        WR_REQ: begin
          if (bus.mem_req_ready)      req_valid_q <= 1'b0;
          if (bus.mem_req_data_ready) wd_valid_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // tag/data arrays: refill fills the whole line, a write hit merges bytes
  always_ff @(posedge clk) begin
    if (state == RD_WAIT && resp_ok) begin
      data_arr[l_idx] <= bus.mem_resp_data;
      tag_arr[l_idx]  <= l_tag;
    end else if (state == IDLE && is_wr && hit) begin
      for (int b = 0; b < 4; b++)
        if (bus.cpu_we[b])
          data_arr[idx][{off, 5'b0} + 7'(b * 8) +: 8] <= bus.cpu_din[b*8 +: 8];
    end
  end

  assign bus.cpu_dout           = dout_q;
  assign bus.stall              = stall_q;
  assign bus.mem_req_valid      = req_valid_q;
  assign bus.mem_req_rw         = req_rw_q;
  assign bus.mem_req_addr       = req_addr_q;
  assign bus.mem_req_tag        = req_tag_q;
  assign bus.mem_req_data_valid = wd_valid_q;
  assign bus.mem_req_data_bits  = wd_bits_q;
  assign bus.mem_req_data_mask  = wd_mask_q;
endmodule

// File: tb/tb_dmem_cache_responder.sv
// Directed bench: a vector table for the hit path plus hand-written
// sequences for refill, write-through, backpressure and abort cases.
module tb_dmem_cache_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_cache_responder_if #(.MEM_TAG_W(5)) bus ();

  dmem_cache_responder #(.LINES(64), .MEM_TAG_W(5), .REQ_TAG(0)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        re;
    logic [31:0] exp_dout;
    logic        exp_stall;
    logic        exp_req;
  } vec_t;

  vec_t vecs[5];
  logic [127:0] line0;
  logic [127:0] line1;

  initial begin
    // read-hit vectors against the line filled at 0x100
    vecs[0] = '{32'h0000_0108, 1'b1, 32'h3333_3333, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_010C, 1'b1, 32'h4444_4444, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0100, 1'b1, 32'h1111_1111, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0200, 1'b0, 32'h1111_1111, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0107, 1'b1, 32'h2222_2222, 1'b0, 1'b0};
    line0 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    line1 = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'h5A5A_5A5A};

    bus.cpu_addr = '0; bus.cpu_re = 0; bus.cpu_we = '0; bus.cpu_din = '0;
    bus.mem_req_ready = 0; bus.mem_req_data_ready = 0;
    bus.mem_resp_valid = 0; bus.mem_resp_data = '0; bus.mem_resp_tag = '0;

    // reset state
    #12;
    chk("rst_stall", bus.stall, 0);
    chk("rst_dout", bus.cpu_dout, 0);
    chk("rst_req_valid", bus.mem_req_valid, 0);
    chk("rst_wd_valid", bus.mem_req_data_valid, 0);
    step();
    reset = 0;

    // cold read miss at 0x104
    bus.cpu_addr = 32'h0000_0104; bus.cpu_re = 1;
    step();
    bus.cpu_re = 0;
    chk("cold_stall", bus.stall, 1);
    chk("cold_req_valid", bus.mem_req_valid, 1);
    chk("cold_req_rw", bus.mem_req_rw, 0);
    chk("cold_req_addr", bus.mem_req_addr, 28'h000_0010);
    chk("cold_req_tag", bus.mem_req_tag, 0);
    bus.mem_req_ready = 1;
    step();
    bus.mem_req_ready = 0;
    chk("cold_wait_stall", bus.stall, 1);
    chk("cold_wait_req", bus.mem_req_valid, 0);
    bus.mem_resp_valid = 1; bus.mem_resp_data = line0; bus.mem_resp_tag = 0;
    step();
    bus.mem_resp_valid = 0;
    chk("cold_done_stall", bus.stall, 0);
    chk("cold_done_dout", bus.cpu_dout, 32'h2222_2222);

    // table: hits and no-request hold
    for (int i = 0; i < 5; i++) begin
      bus.cpu_addr = vecs[i].addr; bus.cpu_re = vecs[i].re;
      step();
      chk($sformatf("vec%0d_dout", i), bus.cpu_dout, vecs[i].exp_dout);
      chk($sformatf("vec%0d_stall", i), bus.stall, vecs[i].exp_stall);
      chk($sformatf("vec%0d_req", i), bus.mem_req_valid, vecs[i].exp_req);
    end
    bus.cpu_re = 0;

    // write hit at 0x104, bytes 0..1
    bus.cpu_addr = 32'h0000_0104; bus.cpu_we = 4'b0011; bus.cpu_din = 32'hAAAA_BBBB;
    step();
    bus.cpu_we = '0;
    chk("wh_stall", bus.stall, 1);
    chk("wh_req_valid", bus.mem_req_valid, 1);
    chk("wh_req_rw", bus.mem_req_rw, 1);
    chk("wh_req_addr", bus.mem_req_addr, 28'h000_0010);
    chk("wh_wd_valid", bus.mem_req_data_valid, 1);
    chk("wh_mask", bus.mem_req_data_mask, 16'h0030);
    chk("wh_bits", bus.mem_req_data_bits, {4{32'hAAAA_BBBB}});
    bus.mem_req_ready = 1; bus.mem_req_data_ready = 1;
    step();
    bus.mem_req_ready = 0; bus.mem_req_data_ready = 0;
    chk("wh_done_stall", bus.stall, 0);
    chk("wh_done_req", bus.mem_req_valid, 0);
    chk("wh_done_wd", bus.mem_req_data_valid, 0);
    bus.cpu_re = 1;
    step();
    bus.cpu_re = 0;
    chk("wh_reread_dout", bus.cpu_dout, 32'h2222_BBBB);
    chk("wh_reread_stall", bus.stall, 0);

    // write miss at 0x2000 with data-channel backpressure
    bus.cpu_addr = 32'h0000_2000; bus.cpu_we = 4'hF; bus.cpu_din = 32'h1234_5678;
    step();
    bus.cpu_we = '0;
    chk("wm_req_valid", bus.mem_req_valid, 1);
    chk("wm_mask", bus.mem_req_data_mask, 16'h000F);
    chk("wm_addr", bus.mem_req_addr, 28'h000_0200);
    bus.mem_req_ready = 1;
    step();
    bus.mem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp%0d_req", i), bus.mem_req_valid, 0);
      chk($sformatf("bp%0d_wd", i), bus.mem_req_data_valid, 1);
      chk($sformatf("bp%0d_stall", i), bus.stall, 1);
      if (i < 2) step();
    end
    bus.mem_req_data_ready = 1;
    step();
    bus.mem_req_data_ready = 0;
    chk("bp_done_stall", bus.stall, 0);
    chk("bp_done_wd", bus.mem_req_data_valid, 0);

    // read of 0x2000 must miss (no allocate); wrong-tag response ignored
    bus.cpu_re = 1;
    step();
    bus.cpu_re = 0;
    chk("na_req_valid", bus.mem_req_valid, 1);
    chk("na_req_rw", bus.mem_req_rw, 0);
    chk("na_stall", bus.stall, 1);
    bus.mem_req_ready = 1;
    step();
    bus.mem_req_ready = 0;
    bus.mem_resp_valid = 1; bus.mem_resp_data = line1; bus.mem_resp_tag = 5'd3;
    step();
    chk("tag3_stall", bus.stall, 1);
    chk("tag3_dout", bus.cpu_dout, 32'h2222_BBBB);
    bus.mem_resp_tag = 0;
    step();
    bus.mem_resp_valid = 0;
    chk("tag0_stall", bus.stall, 0);
    chk("tag0_dout", bus.cpu_dout, 32'h5A5A_5A5A);

    // reset during RD_WAIT, then a late response in IDLE
    bus.cpu_addr = 32'h0000_0300; bus.cpu_re = 1;
    step();
    bus.cpu_re = 0;
    bus.mem_req_ready = 1;
    step();
    bus.mem_req_ready = 0;
    chk("abort_wait_stall", bus.stall, 1);
    reset = 1;
    #2;
    chk("abort_rst_stall", bus.stall, 0);
    chk("abort_rst_dout", bus.cpu_dout, 0);
    chk("abort_rst_req", bus.mem_req_valid, 0);
    reset = 0;
    bus.mem_resp_valid = 1; bus.mem_resp_data = line1; bus.mem_resp_tag = 0;
    step();
    bus.mem_resp_valid = 0;
    chk("late_resp_stall", bus.stall, 0);
    chk("late_resp_dout", bus.cpu_dout, 0);
    bus.cpu_re = 1;
    step();
    bus.cpu_re = 0;
    chk("reread_miss_req", bus.mem_req_valid, 1);
    chk("reread_miss_rw", bus.mem_req_rw, 0);
    chk("reread_miss_addr", bus.mem_req_addr, 28'h000_0030);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_cache_responder.md
Name: dmem_cache_responder

Overview:
- Memory-side responder for the core's data memory port.
- Accepts the core's address, read-enable and byte write-enables.
- Returns read data one cycle later on a hit, and drives `stall` while it refills from or writes through to main memory.
- Direct-mapped, write-through, no-write-allocate cache. It sits between the core's dcache port and the 128-bit main-memory request/response interface.

Parameters:
- LINES, 64, number of cache lines (power of 2, ≥2); each line is 128 bits (4 words).
- MEM_TAG_W, 5, width of the main-memory transaction tag.
- REQ_TAG, 0, constant tag value issued on refill requests and matched on responses.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cpu_addr  input  32  byte address from core; [1:0] ignored.
- cpu_re  input  1  read request.
- cpu_we  input  4  byte write enables; any bit set means write.
- cpu_din  input  32  store data, byte lanes aligned to the word.
- cpu_dout  output  32  read data, registered.
- stall  output  1  core must freeze while high, registered.
- mem_req_valid  output  1  main-memory request valid.
- mem_req_ready  input  1  main-memory request accepted.
- mem_req_rw  output  1  1 = write, 0 = read.
- mem_req_addr  output  28  line address = cpu_addr[31:4].
- mem_req_tag  output  MEM_TAG_W  transaction tag.
- mem_req_data_valid  output  1  write data valid.
- mem_req_data_ready  input  1  write data accepted.
- mem_req_data_bits  output  128  write data.
- mem_req_data_mask  output  16  byte mask for write data.
- mem_resp_valid  input  1  read response valid.
- mem_resp_data  input  128  refill line.
- mem_resp_tag  input  MEM_TAG_W  response tag.

Behaviour:
- Address split:
  - offset = addr[3:2].
  - index = addr[4+log2(LINES)-1:4].
  - tag = addr[31:4+log2(LINES)].
  - Hit = valid[index] && tag match.
- Reset (async): state=IDLE; all valid bits cleared; cpu_dout=0; stall=0; all mem_* outputs 0. Tag and data arrays need no reset.
- A request is sampled only in IDLE. Inputs presented while stall=1 are ignored.
- If cpu_re and cpu_we≠0 occur together, the request is a write.
- IDLE:
  - Read hit: cpu_dout <= line word[offset] at the next edge; stay IDLE. Latency is 1 cycle with stall=0.
  - Read miss: latch addr; go to RD_REQ.
  - Write: latch addr/din/we; if hit, merge enabled bytes into the line at this edge; go to WR_REQ.
  - No request: hold cpu_dout.
- RD_REQ:
  - Drive mem_req_valid=1, rw=0, addr=latched[31:4], tag=REQ_TAG.
  - On mem_req_ready: go to RD_WAIT.
- RD_WAIT:
  - On mem_resp_valid && mem_resp_tag==REQ_TAG: write the line, set tag, set valid; cpu_dout <= resp word[offset] (word 0 = bits[31:0]); go to IDLE.
  - A response with any other tag is ignored.
- WR_REQ:
  - Drive mem_req_valid (rw=1) and mem_req_data_valid together.
  - Each handshake is tracked independently. Each valid drops after its own ready; the two may complete in the same or different cycles.
  - mem_req_data_bits = {4{din}}.
  - mem_req_data_mask = we << (4*offset).
  - Go to IDLE once both handshakes have completed.
- A write miss does not allocate or modify the cache.
- stall = (state != IDLE), registered. On the first cycle stall drops after a read miss, cpu_dout holds the requested word.
- Minimum stall durations:
  - Write: ≥1 cycle.
  - Read miss: ≥2 cycles.
- Reset mid-transaction: the transaction is abandoned and the line stays invalid. A late mem response arriving in IDLE is ignored.
- mem_* valid outputs never deassert before their ready is seen.

Test Plan:
- Cold read, addr 0x0000_0104: stall=1 next cycle; mem_req addr=0x0000010, rw=0, tag=0. Respond with data 0x44..._33..._22..._11 (word0=0x11111111, word1=0x22222222). Required: stall=0 and cpu_dout=0x22222222 on the following cycle.
- Read 0x0000_0108 after the previous fill: no mem_req; cpu_dout=word2 one cycle later; stall stays 0.
- Write hit, addr 0x104, we=4'b0011, din=0xAAAA_BBBB:
  - mem_req_data_mask=16'h0030.
  - data_bits = {4{0xAAAABBBB}}.
  - A subsequent read of 0x104 hits with value 0x2222BBBB.
- Write miss, addr 0x2000: mem write issued. A subsequent read of 0x2000 misses (mem_req rw=0 seen), proving no allocate.
- Backpressure: hold mem_req_data_ready low for 3 cycles after mem_req_ready. Required: mem_req_data_valid stays high, stall stays high, and IDLE is re-entered only after both handshakes.
- Refill interrupted:
  - Assert reset in RD_WAIT, then send the response (tag 0) while in IDLE: response is ignored; a reread misses.
  - Separately, a response with tag 3 in RD_WAIT is ignored and stall stays 1.
